// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage.
// Covers control-word bit positions and instruction field slices.
package decode_pkg;

    // Control word bit positions
    localparam int CTRL_REGWRITE     = 0;
    localparam int CTRL_MEMWRITE     = 1;
    localparam int CTRL_JUMP         = 2;
    localparam int CTRL_BRANCH       = 3;
    localparam int CTRL_ALUSRC       = 4;
    localparam int CTRL_RESULTSRC_LO = 5;
    localparam int CTRL_RESULTSRC_HI = 6;
    localparam int CTRL_ALUCTRL_LO   = 7;
    localparam int CTRL_ALUCTRL_HI   = 9;
    localparam int CTRL_MIN_W        = CTRL_ALUCTRL_HI + 1;

    // Instruction layout: op[15:12] Rd[11:8] Rm[7:4] Rn[3:0], imm flag [0]
    localparam int INST_W   = 16;
    localparam int FIELD_W  = 4;
    localparam int OP_HI    = 15;
    localparam int OP_LO    = 12;
    localparam int RD_HI    = 11;
    localparam int RD_LO    = 8;
    localparam int RM_HI    = 7;
    localparam int RM_LO    = 4;
    localparam int RN_HI    = 3;
    localparam int RN_LO    = 0;
    localparam int IMMF_BIT = 0;

    // The jump target is inst[11:0] shifted left by one
    localparam int JTGT_HI = 11;
    localparam int JTGT_W  = JTGT_HI + 2;

    // Extract one 4-bit register field starting at bit lo
    function automatic logic [FIELD_W-1:0] inst_field(input logic [INST_W-1:0] inst,
                                                      input int lo);
        return inst[lo +: FIELD_W];
    endfunction

endpackage

// File: rtl/regfile_p.sv
// Register file with two combinational read ports and one write port.
// A same-cycle write to a read index is forwarded to that read port.
// With R0_ZERO set, register 0 is hardwired to zero and is never bypassed.
module regfile_p #(
    parameter int  DATA_W  = 16,
    parameter int  NREG    = 16,
    parameter int  R0_ZERO = 1,
    localparam int RA_W    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RA_W-1:0]   i_ra1,
    input  logic [RA_W-1:0]   i_ra2,
    input  logic              i_we,
    input  logic [RA_W-1:0]   i_wa,
    input  logic [DATA_W-1:0] i_wd,
    output logic [DATA_W-1:0] o_rd1,
    output logic [DATA_W-1:0] o_rd2
);

    logic [DATA_W-1:0] w_regs [NREG];
    logic              w_byp1;
    logic              w_byp2;

    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        if (R0_ZERO != 0 && gi == 0) begin : g_zero
            assign w_regs[gi] = '0;
        end else begin : g_store
            logic [DATA_W-1:0] r_q;
            // One storage word; loads only when writeback targets this index
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_q <= '0;
                end else if (i_we && (i_wa == RA_W'(gi))) begin
                    r_q <= i_wd;
                end
            end
            assign w_regs[gi] = r_q;
        end
    end

    // Forward the writeback value when it targets a port's index (not hardwired R0)
    assign w_byp1 = i_we && (i_wa == i_ra1) && !((R0_ZERO != 0) && (i_ra1 == '0));
    assign w_byp2 = i_we && (i_wa == i_ra2) && !((R0_ZERO != 0) && (i_ra2 == '0));

    assign o_rd1 = w_byp1 ? i_wd : w_regs[i_ra1];
    assign o_rd2 = w_byp2 ? i_wd : w_regs[i_ra2];

endmodule

// File: rtl/decode_pipe.sv
// Decode stage is made up of four parts:
//   - operand read through regfile_p,
//   - immediate and jump-target generation,
//   - load-use hazard detection,
//   - the ID/EX pipeline register.
// The ID/EX register updates with this priority: flush, then stall, then
// load-use bubble, then normal load.
module decode_pipe
    import decode_pkg::*;
#(
    parameter int  DATA_W  = 16,
    parameter int  NREG    = 16,
    parameter int  IMM_W   = 7,
    parameter int  CTRL_W  = 12,
    parameter int  R0_ZERO = 1,
    localparam int RA_W    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instValidD,
    input  logic [15:0]       inst,
    input  logic [DATA_W-1:0] PCPlus2,
    input  logic [CTRL_W-1:0] ctrlD,
    input  logic              a1Source,
    input  logic              zeroOp1,
    input  logic              isLoadD,
    input  logic              flushE,
    input  logic              stallE,
    input  logic              regWriteWB,
    input  logic [RA_W-1:0]   RdestW,
    input  logic [DATA_W-1:0] resultWB,
    output logic              stallD,
    output logic              validE,
    output logic              isLoadE,
    output logic [DATA_W-1:0] RD1E,
    output logic [DATA_W-1:0] RD2E,
    output logic [DATA_W-1:0] PCE,
    output logic [DATA_W-1:0] PCPlus2E,
    output logic [DATA_W-1:0] immExtE,
    output logic [RA_W-1:0]   RdE,
    output logic [RA_W-1:0]   Ra1E,
    output logic [RA_W-1:0]   Ra2E,
    output logic [CTRL_W-1:0] ctrlE
);

    // Decode-side signals
    logic [FIELD_W-1:0] w_rd_full;
    logic [FIELD_W-1:0] w_rm_full;
    logic [FIELD_W-1:0] w_rn_full;
    logic [RA_W-1:0]    w_rd_idx;
    logic [RA_W-1:0]    w_a1;
    logic [RA_W-1:0]    w_a2;
    logic [DATA_W-1:0]  w_port1;
    logic [DATA_W-1:0]  w_port2;
    logic [DATA_W-1:0]  w_op1;
    logic [IMM_W-1:0]   w_imm_field;
    logic [DATA_W-1:0]  w_imm_ext;
    logic [DATA_W-1:0]  w_jump_tgt;
    logic               w_load_use;
    logic               w_unused_op;

    // ID/EX register
    logic               r_valid_e;
    logic               r_is_load_e;
    logic [CTRL_W-1:0]  r_ctrl_e;
    logic [DATA_W-1:0]  r_rd1_e;
    logic [DATA_W-1:0]  r_rd2_e;
    logic [DATA_W-1:0]  r_pc_e;
    logic [DATA_W-1:0]  r_pc_plus2_e;
    logic [DATA_W-1:0]  r_imm_e;
    logic [RA_W-1:0]    r_rd_e;
    logic [RA_W-1:0]    r_ra1_e;
    logic [RA_W-1:0]    r_ra2_e;

    // Register fields, truncated to the index width of this register file
    assign w_rd_full = inst_field(inst, RD_LO);
    assign w_rm_full = inst_field(inst, RM_LO);
    assign w_rn_full = inst_field(inst, RN_LO);
    assign w_rd_idx  = w_rd_full[RA_W-1:0];

    // Set/compare forms read Rd on both ports
    assign w_a1 = a1Source ? w_rd_idx : w_rm_full[RA_W-1:0];
    assign w_a2 = a1Source ? w_rd_idx : w_rn_full[RA_W-1:0];

    // The opcode is consumed by the control unit, not here
    assign w_unused_op = ^inst[OP_HI:OP_LO];

    regfile_p #(
        .DATA_W  (DATA_W),
        .NREG    (NREG),
        .R0_ZERO (R0_ZERO)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .i_ra1 (w_a1),
        .i_ra2 (w_a2),
        .i_we  (regWriteWB),
        .i_wa  (RdestW),
        .i_wd  (resultWB),
        .o_rd1 (w_port1),
        .o_rd2 (w_port2)
    );

    assign w_op1       = zeroOp1 ? '0 : w_port1;
    assign w_imm_field = inst[IMM_W:1];
    assign w_imm_ext   = {{(DATA_W-IMM_W){w_imm_field[IMM_W-1]}}, w_imm_field};
    assign w_jump_tgt  = {{(DATA_W-JTGT_W){1'b0}}, inst[JTGT_HI:0], 1'b0};

    // A load in execute whose destination a valid decode instruction reads
    assign w_load_use = instValidD & r_valid_e & r_is_load_e & r_ctrl_e[CTRL_REGWRITE]
                      & ((r_rd_e == w_a1) | (r_rd_e == w_a2));

    // A flush kills the consumer, so a load-use hazard then needs no hold
    assign stallD = stallE | (w_load_use & ~flushE);

    // ID/EX register: flush and bubble clear control only; data fields are don't-care then
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid_e    <= 1'b0;
            r_is_load_e  <= 1'b0;
            r_ctrl_e     <= '0;
            r_rd1_e      <= '0;
            r_rd2_e      <= '0;
            r_pc_e       <= '0;
            r_pc_plus2_e <= '0;
            r_imm_e      <= '0;
            r_rd_e       <= '0;
            r_ra1_e      <= '0;
            r_ra2_e      <= '0;
        end else if (flushE) begin
            r_valid_e   <= 1'b0;
            r_is_load_e <= 1'b0;
            r_ctrl_e    <= '0;
        end else if (!stallE) begin
            if (w_load_use) begin
                r_valid_e   <= 1'b0;
                r_is_load_e <= 1'b0;
                r_ctrl_e    <= '0;
            end else begin
                r_valid_e    <= instValidD;
                r_is_load_e  <= instValidD & isLoadD;
                r_ctrl_e     <= instValidD ? ctrlD : '0;
                r_rd1_e      <= w_op1;
                r_rd2_e      <= w_port2;
                r_pc_e       <= w_jump_tgt;
                r_pc_plus2_e <= PCPlus2;
                r_imm_e      <= w_imm_ext;
                r_rd_e       <= w_rd_idx;
                r_ra1_e      <= w_a1;
                r_ra2_e      <= w_a2;
            end
        end
    end

    assign validE   = r_valid_e;
    assign isLoadE  = r_is_load_e;
    assign ctrlE    = r_ctrl_e;
    assign RD1E     = r_rd1_e;
    assign RD2E     = r_rd2_e;
    assign PCE      = r_pc_e;
    assign PCPlus2E = r_pc_plus2_e;
    assign immExtE  = r_imm_e;
    assign RdE      = r_rd_e;
    assign Ra1E     = r_ra1_e;
    assign Ra2E     = r_ra2_e;

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe.
// Runs directed vectors with literal expectations, plus a spec-level model
// that is compared against the DUT on every falling clock edge.
module tb_decode_pipe;

    localparam int DW = 16;
    localparam int CW = 12;

    logic          clk;
    logic          rst;
    logic          instValidD, a1Source, zeroOp1, isLoadD, flushE, stallE, regWriteWB;
    logic [15:0]   inst;
    logic [DW-1:0] PCPlus2, resultWB;
    logic [CW-1:0] ctrlD;
    logic [3:0]    RdestW;

    logic          stallD, validE, isLoadE;
    logic [DW-1:0] RD1E, RD2E, PCE, PCPlus2E, immExtE;
    logic [3:0]    RdE, Ra1E, Ra2E;
    logic [CW-1:0] ctrlE;

    // 32-bit instance fed from the same stimulus
    logic [31:0]   PCPlus2_32, resultWB_32;
    logic          stallD32, validE32, isLoadE32;
    logic [31:0]   RD1E32, RD2E32, PCE32, PCPlus2E32, immExtE32;
    logic [3:0]    RdE32, Ra1E32, Ra2E32;
    logic [CW-1:0] ctrlE32;

    assign PCPlus2_32  = {16'h0000, PCPlus2};
    assign resultWB_32 = {16'h0000, resultWB};

    int n_err = 0;
    int n_chk = 0;
    int n_txn = 0;
    bit chk_en = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    decode_pipe #(.DATA_W(16)) dut (
        .clk(clk), .rst(rst), .instValidD(instValidD), .inst(inst), .PCPlus2(PCPlus2),
        .ctrlD(ctrlD), .a1Source(a1Source), .zeroOp1(zeroOp1), .isLoadD(isLoadD),
        .flushE(flushE), .stallE(stallE), .regWriteWB(regWriteWB), .RdestW(RdestW),
        .resultWB(resultWB), .stallD(stallD), .validE(validE), .isLoadE(isLoadE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus2E(PCPlus2E), .immExtE(immExtE),
        .RdE(RdE), .Ra1E(Ra1E), .Ra2E(Ra2E), .ctrlE(ctrlE)
    );

    decode_pipe #(.DATA_W(32)) dut32 (
        .clk(clk), .rst(rst), .instValidD(instValidD), .inst(inst), .PCPlus2(PCPlus2_32),
        .ctrlD(ctrlD), .a1Source(a1Source), .zeroOp1(zeroOp1), .isLoadD(isLoadD),
        .flushE(flushE), .stallE(stallE), .regWriteWB(regWriteWB), .RdestW(RdestW),
        .resultWB(resultWB_32), .stallD(stallD32), .validE(validE32), .isLoadE(isLoadE32),
        .RD1E(RD1E32), .RD2E(RD2E32), .PCE(PCE32), .PCPlus2E(PCPlus2E32), .immExtE(immExtE32),
        .RdE(RdE32), .Ra1E(Ra1E32), .Ra2E(Ra2E32), .ctrlE(ctrlE32)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_regs [16];
    logic          m_valid, m_isload, m_known;
    logic [CW-1:0] m_ctrl;
    logic [DW-1:0] m_rd1, m_rd2, m_pce, m_pcp2, m_imm;
    logic [3:0]    m_rd, m_ra1, m_ra2;

    function automatic int src1();
        return a1Source ? int'(inst[11:8]) : int'(inst[7:4]);
    endfunction

    function automatic int src2();
        return a1Source ? int'(inst[11:8]) : int'(inst[3:0]);
    endfunction

    // Register value seen by decode this cycle, including a same-cycle writeback
    function automatic logic [DW-1:0] m_read(input int idx);
        if (idx == 0) return '0;
        if (regWriteWB && int'(RdestW) == idx) return resultWB;
        return m_regs[idx];
    endfunction

    function automatic logic m_load_use();
        return instValidD && m_valid && m_isload && m_ctrl[0]
            && (int'(m_rd) == src1() || int'(m_rd) == src2());
    endfunction

    function automatic logic [DW-1:0] m_jump();
        int v;
        v = int'(inst[11:0]) * 2;
        return v[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] m_immval();
        int v;
        v = int'(inst[7:1]);
        if (v >= 64) v = v - 128;
        return v[DW-1:0];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0; m_isload <= 1'b0; m_ctrl <= '0; m_known <= 1'b1;
            m_rd1 <= '0; m_rd2 <= '0; m_pce <= '0; m_pcp2 <= '0; m_imm <= '0;
            m_rd <= '0; m_ra1 <= '0; m_ra2 <= '0;
            for (int i = 0; i < 16; i++) m_regs[i] <= '0;
        end else begin
            if (flushE || (!stallE && m_load_use())) begin
                m_valid <= 1'b0; m_isload <= 1'b0; m_ctrl <= '0; m_known <= 1'b0;
            end else if (!stallE) begin
                m_valid  <= instValidD;
                m_isload <= instValidD & isLoadD;
                m_ctrl   <= instValidD ? ctrlD : '0;
                m_rd1    <= zeroOp1 ? '0 : m_read(src1());
                m_rd2    <= m_read(src2());
                m_pce    <= m_jump();
                m_pcp2   <= PCPlus2;
                m_imm    <= m_immval();
                m_rd     <= inst[11:8];
                m_ra1    <= 4'(src1());
                m_ra2    <= 4'(src2());
                m_known  <= 1'b1;
            end
            if (regWriteWB && RdestW != 4'd0) m_regs[RdestW] <= resultWB;
        end
    end

    // Single compare process, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stallD", stallD, stallE | (m_load_use() & ~flushE));
            chk("validE", validE, m_valid);
            chk("ctrlE", ctrlE, m_ctrl);
            chk("isLoadE", isLoadE, m_isload);
            chk("stallD32", stallD32, stallE | (m_load_use() & ~flushE));
            chk("validE32", validE32, m_valid);
            chk("ctrlE32", ctrlE32, m_ctrl);
            chk("isLoadE32", isLoadE32, m_isload);
            if (m_known) begin
                chk("RD1E", RD1E, m_rd1);
                chk("RD2E", RD2E, m_rd2);
                chk("PCE", PCE, m_pce);
                chk("PCPlus2E", PCPlus2E, m_pcp2);
                chk("immExtE", immExtE, m_imm);
                chk("RdE", RdE, m_rd);
                chk("Ra1E", Ra1E, m_ra1);
                chk("Ra2E", Ra2E, m_ra2);
                chk("RD1E32", RD1E32, m_rd1);
                chk("RD2E32", RD2E32, m_rd2);
                chk("PCE32", PCE32, m_pce);
                chk("PCPlus2E32", PCPlus2E32, m_pcp2);
                chk("immExtE32", immExtE32, {{16{m_imm[15]}}, m_imm});
                chk("RdE32", RdE32, m_rd);
                chk("Ra1E32", Ra1E32, m_ra1);
                chk("Ra2E32", Ra2E32, m_ra2);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        instValidD = 0; inst = '0; ctrlD = '0; a1Source = 0; zeroOp1 = 0; isLoadD = 0;
        flushE = 0; stallE = 0; regWriteWB = 0; RdestW = '0; resultWB = '0; PCPlus2 = '0;
    endtask

    task automatic dec(input logic [15:0] i, input logic [CW-1:0] c, input logic ld);
        instValidD = 1; inst = i; ctrlD = c; isLoadD = ld;
    endtask

    task automatic wb(input logic [3:0] r, input logic [15:0] d);
        regWriteWB = 1; RdestW = r; resultWB = d;
    endtask

    task automatic tick();
        n_txn++;
        $display("txn %0d: inst=%h v=%b ctrl=%h ld=%b a1s=%b z=%b fl=%b st=%b wb=%b R%0d=%h",
                 n_txn, inst, instValidD, ctrlD, isLoadD, a1Source, zeroOp1, flushE, stallE,
                 regWriteWB, RdestW, resultWB);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0]   i;
        logic [CW-1:0] c;
        logic          ld;
        logic          a1s;
        logic          we;
        logic [3:0]    wa;
        logic [15:0]   wd;
    } vec_t;
    vec_t tbl[$];

    initial begin
        idle();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        // Reset state, no clock edge yet
        chk("rst_validE", validE, 1'b0);
        chk("rst_ctrlE", ctrlE, '0);
        chk("rst_RD1E", RD1E, '0);
        chk("rst_PCE", PCE, '0);
        chk("rst_stallD", stallD, 1'b0);
        stallE = 1;
        #1;
        chk("rst_stallD_follows_stallE", stallD, 1'b1);
        stallE = 0;
        #1 chk_en = 1'b1;
        #3 rst = 1'b1;
        tick();

        // Writeback R3 while decode reads Rm=3
        idle(); wb(4'd3, 16'h00A5); dec(16'h1130, 12'h001, 0); PCPlus2 = 16'h0102;
        tick();
        chk("bypass_RD1E", RD1E, 16'h00A5);
        chk("bypass_RD2E", RD2E, 16'h0000);
        chk("bypass_PCPlus2E", PCPlus2E, 16'h0102);
        chk("bypass_Ra1E", Ra1E, 4'd3);

        // a1Source: both ports read Rd=3
        idle(); dec(16'h6300, 12'h001, 0); a1Source = 1;
        tick();
        chk("a1src_RD1E", RD1E, 16'h00A5);
        chk("a1src_RD2E", RD2E, 16'h00A5);
        chk("a1src_Ra2E", Ra2E, 4'd3);

        // Invalid decode masks control; write R4 meanwhile
        idle(); wb(4'd4, 16'h0044); ctrlD = 12'hFFF; isLoadD = 1;
        tick();
        chk("inval_validE", validE, 1'b0);
        chk("inval_ctrlE", ctrlE, '0);

        // R0 ignores writes and reads zero, even with same-cycle write
        idle(); wb(4'd0, 16'h1234); dec(16'h1100, 12'h001, 0);
        tick();
        chk("r0_same_cycle", RD1E, 16'h0000);
        idle(); dec(16'h1100, 12'h001, 0);
        tick();
        chk("r0_after_write", RD1E, 16'h0000);

        // zeroOp1 forces op1 to zero
        idle(); dec(16'h1033, 12'h001, 0); zeroOp1 = 1;
        tick();
        chk("zeroop_RD1E", RD1E, 16'h0000);
        chk("zeroop_RD2E", RD2E, 16'h00A5);

        // Load to R2, consumer reads Rn=2
        idle(); dec(16'h2200, 12'h001, 1);
        tick();
        idle(); dec(16'h3642, 12'h001, 0);
        #1 chk("lu_stallD", stallD, 1'b1);
        tick();
        chk("lu_bubble_validE", validE, 1'b0);
        chk("lu_bubble_ctrlE", ctrlE, '0);
        wb(4'd2, 16'h0BEE);
        #1 chk("lu_release_stallD", stallD, 1'b0);
        tick();
        chk("lu_consumer_validE", validE, 1'b1);
        chk("lu_consumer_RD2E", RD2E, 16'h0BEE);
        chk("lu_consumer_RD1E", RD1E, 16'h0044);
        chk("lu_consumer_RdE", RdE, 4'd6);

        // Flush together with load-use
        idle(); dec(16'h2700, 12'h001, 1);
        tick();
        idle(); dec(16'h3807, 12'h001, 0); flushE = 1;
        #1 chk("flush_stallD", stallD, 1'b0);
        tick();
        chk("flush_validE", validE, 1'b0);
        chk("flush_ctrlE", ctrlE, '0);
        chk("flush_isLoadE", isLoadE, 1'b0);

        // stallE for three cycles holds everything
        idle(); dec(16'h4912, 12'hABC, 0); PCPlus2 = 16'h0200;
        tick();
        chk("st_load_ctrlE", ctrlE, 12'hABC);
        for (int k = 0; k < 3; k++) begin
            idle(); dec(16'h5A34, 12'h555, 1); PCPlus2 = 16'h0300; stallE = 1;
            #1 chk("st_stallD", stallD, 1'b1);
            tick();
            chk("st_hold_ctrlE", ctrlE, 12'hABC);
            chk("st_hold_PCPlus2E", PCPlus2E, 16'h0200);
            chk("st_hold_RD2E", RD2E, 16'h0BEE);
            chk("st_hold_RdE", RdE, 4'd9);
        end
        stallE = 0;
        tick();
        chk("st_release_ctrlE", ctrlE, 12'h555);
        chk("st_release_isLoadE", isLoadE, 1'b1);

        // Immediate and jump target, both widths
        idle(); dec(16'h00FE, 12'h000, 0);
        tick();
        chk("imm_neg16", immExtE, 16'hFFFF);
        chk("imm_neg32", immExtE32, 32'hFFFFFFFF);
        chk("jt_1fc", PCE, 16'h01FC);
        idle(); dec(16'h0800, 12'h000, 0);
        tick();
        chk("jt_16", PCE, 16'h1000);
        chk("jt_32", PCE32, 32'h00001000);
        chk("imm_zero", immExtE, 16'h0000);
        idle(); dec(16'h007E, 12'h000, 0);
        tick();
        chk("imm_pos", immExtE, 16'h003F);

        // Short directed sequence covered by the model
        tbl.push_back('{16'h2520, 12'h001, 1'b1, 1'b0, 1'b1, 4'd6, 16'h6666});
        tbl.push_back('{16'h3157, 12'h001, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000});
        tbl.push_back('{16'h3157, 12'h001, 1'b0, 1'b0, 1'b1, 4'd5, 16'h5A5A});
        tbl.push_back('{16'h4500, 12'h0F0, 1'b0, 1'b1, 1'b1, 4'd5, 16'h5555});
        tbl.push_back('{16'h5600, 12'h001, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000});
        tbl.push_back('{16'h6600, 12'h001, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000});
        tbl.push_back('{16'h6600, 12'h001, 1'b0, 1'b1, 1'b1, 4'd6, 16'hC0DE});
        tbl.push_back('{16'h7F00, 12'h000, 1'b0, 1'b0, 1'b1, 4'd15, 16'hFACE});
        foreach (tbl[n]) begin
            idle(); dec(tbl[n].i, tbl[n].c, tbl[n].ld); a1Source = tbl[n].a1s;
            PCPlus2 = 16'h0400 + 16'(n * 2);
            if (tbl[n].we) wb(tbl[n].wa, tbl[n].wd);
            tick();
        end

        // Reset mid-operation: load in E and consumer stalled
        idle(); dec(16'h7345, 12'h0F1, 1);
        tick();
        idle(); dec(16'h8030, 12'h001, 0);
        #1 chk("rst_mid_stallD_before", stallD, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk("rst_mid_validE", validE, 1'b0);
        chk("rst_mid_ctrlE", ctrlE, '0);
        chk("rst_mid_isLoadE", isLoadE, 1'b0);
        chk("rst_mid_RD1E", RD1E, '0);
        chk("rst_mid_immExtE", immExtE, '0);
        chk("rst_mid_RdE", RdE, '0);
        chk("rst_mid_stallD", stallD, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        idle(); dec(16'h1030, 12'h001, 0);
        tick();
        chk("rst_cleared_R3", RD1E, 16'h0000);
        chk("rst_cleared_valid", validE, 1'b1);

        idle();
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter DATA_W, default 16: datapath width of register data, PC and immediates; legal 16..64.
REQ-002 Parameter NREG, default 16: register count; index width RA_W = clog2(NREG); legal 4..16.
REQ-003 Parameter IMM_W, default 7: immediate field width, taken from inst[IMM_W:1].
REQ-004 Parameter CTRL_W, default 12: width of the packed control word.
REQ-005 Parameter R0_ZERO, default 1: when 1, register 0 always reads zero and ignores writes.
REQ-006 clk  in  1  rising-edge clock; single clock domain.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 instValidD  in  1  fetch presents a valid instruction.
REQ-009 inst  in  16  instruction: op[15:12], Rd[11:8], Rm[7:4], Rn[3:0], imm flag [0].
REQ-010 PCPlus2  in  DATA_W  PC+2 of inst.
REQ-011 ctrlD  in  CTRL_W  control word from the control unit for inst.
REQ-012 a1Source  in  1  1 = read ports use Rd (set/cmp forms); 0 = read ports use Rm, Rn.
REQ-013 zeroOp1  in  1  1 = force op1 to zero.
REQ-014 isLoadD  in  1  inst is a memory load.
REQ-015 flushE  in  1  branch/jump taken in execute; kill the instruction entering execute.
REQ-016 stallE  in  1  downstream cannot accept; hold the ID/EX register.
REQ-017 regWriteWB  in  1  writeback enable.
REQ-018 RdestW  in  RA_W  writeback register index.
REQ-019 resultWB  in  DATA_W  writeback data.
REQ-020 stallD  out  1  fetch must hold inst/PC this cycle.
REQ-021 validE, isLoadE  out  1 each  execute holds a real instruction / a load.
REQ-022 RD1E, RD2E, PCE, PCPlus2E, immExtE  out  DATA_W each  registered operands, jump target, PC+2, immediate.
REQ-023 RdE, Ra1E, Ra2E  out  RA_W each  registered destination and source indices, used by the forwarding unit.
REQ-024 ctrlE  out  CTRL_W  registered control word.

Function
REQ-025 Source indices: A1 = a1Source ? Rd : Rm; A2 = a1Source ? Rd : Rn; each truncated to RA_W bits.
REQ-026 Register file: combinational read, write on clk rising edge when regWriteWB=1.
REQ-027 Write-through bypass: when regWriteWB=1 and RdestW equals a read index in the same cycle, that port returns resultWB, except index 0 when R0_ZERO=1.
REQ-028 immExt = inst[IMM_W:1] sign-extended to DATA_W.
REQ-029 Jump target = {inst[11:0],1'b0} zero-extended to DATA_W.
REQ-030 op1 = zeroOp1 ? 0 : port-1 data.
REQ-031 loadUse = instValidD & validE & isLoadE & ctrlE regWrite bit & (RdE==A1 | RdE==A2); regWrite is bit 0 of the control word.
REQ-032 stallD = stallE | (loadUse & ~flushE).
REQ-033 ID/EX update priority on each edge: flushE, then stallE, then loadUse, then normal.
REQ-034 flushE=1: validE, ctrlE and isLoadE clear; data fields don't-care.
REQ-035 stallE=1 with flushE=0: all E outputs hold.
REQ-036 loadUse=1 with no flush or stall: a bubble is inserted (validE, ctrlE, isLoadE clear) and the decode inputs are re-presented next cycle.
REQ-037 Normal update: all E outputs load the decode values; validE = instValidD, and ctrlE and isLoadE are masked to 0 when instValidD=0.
REQ-038 Latency: one cycle from decode to E outputs; a load-use costs exactly one bubble.

Reset
REQ-039 While rst=0, all E outputs are zero, validE=0 and all registers are zero, asynchronously.
REQ-040 Reset mid-stall or mid-bubble discards the pending state, and stallD follows its combinational definition from zeroed state.

Structure
REQ-041 A shared package decode_pkg holds the control-word bit positions (REGWRITE=0, MEMWRITE, JUMP, BRANCH, ALUSRC, RESULTSRC[1:0], ALUCTRL[2:0]) and the opcode field slice constants.
REQ-042 The register file is the sub-module regfile_p, parametrised by DATA_W, NREG and R0_ZERO, with the bypass inside it.
REQ-043 Hazard logic and the ID/EX register stay in decode_pipe, with no latches.

Verification
REQ-044 Writeback R3=0x00A5 while decode reads Rm=3 in the same cycle -> next cycle RD1E=0x00A5.
REQ-045 Load to R2 in E, next inst reads Rn=2 -> stallD=1 for one cycle, one bubble with validE=0, then RD2E holds the consumer's operands.
REQ-046 flushE=1 together with loadUse=1 -> validE=0, ctrlE=0, stallD=0.
REQ-047 stallE=1 for 3 cycles -> E outputs stable and stallD=1 throughout.
REQ-048 inst imm field 0x7F -> immExtE=0xFFFF; inst[11:0]=0x800 -> PCE=0x1000; DATA_W=32 repeat -> 0xFFFFFFFF / 0x00001000.
REQ-049 rst pulsed low mid-operation -> all outputs 0 without a clock edge; R0_ZERO=1: writing R0=0x1234 then reading R0 -> 0.
